// File: rtl/opb_register_ppc2simulink.sv
// rtl/opb_register_ppc2simulink.sv - OPB slave register written by the PPC, read by fabric logic
module opb_register_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01080200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010802FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_INIT       = 32'h00000000,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_valid
);

  typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

  state_t      state;
  state_t      state_next;
  logic        rnw_q;
  logic        reg_hit_q;
  logic [3:0]  be_q;       // be_q[3] is OPB_BE[0], the most significant lane
  logic [31:0] wdata_q;    // wdata_q[31] is OPB_DBus[0]
  logic [31:0] reg_q;
  logic [31:0] merged;
  logic        valid_q;
  logic        addr_hit;
  logic        reg_hit;
  logic        ack;
  logic        commit;
  logic        unused_inputs;

  // The burst hint and informational parameters have no effect on this slave.
  assign unused_inputs = ^{OPB_seqAddr, C_OPB_AWIDTH[0], C_OPB_DWIDTH[0], C_FAMILY[0]};

  assign addr_hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign reg_hit  = (OPB_ABus[0:29] == C_BASEADDR[31:2]);

  // State register.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and ack; the GAP state keeps a long select from being acked twice in a row.
  always_comb begin
    state_next = state;
    ack        = 1'b0;
    case (state)
      IDLE: if (addr_hit) state_next = ACK;
      ACK: begin
        ack        = OPB_select;
        state_next = GAP;
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      rnw_q     <= 1'b0;
      reg_hit_q <= 1'b0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
    end else if ((state == IDLE) && addr_hit) begin
      rnw_q     <= OPB_RNW;
      reg_hit_q <= reg_hit;
      be_q      <= OPB_BE;
      wdata_q   <= OPB_DBus;
    end
  end

  assign commit = ack && !rnw_q && reg_hit_q;

  // Byte-lane merge: enabled lanes take write data, the rest keep the register value.
  always_comb begin
    merged = reg_q;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Register update and valid strobe, both visible the cycle after the ack.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      reg_q   <= C_INIT;
      valid_q <= 1'b0;
    end else begin
      valid_q <= commit;
      if (commit) reg_q <= merged;
    end
  end

  assign Sl_xferAck      = ack;
  assign Sl_DBus         = (ack && rnw_q && reg_hit_q) ? reg_q : 32'h0;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = reg_q;
  assign user_data_valid = valid_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// tb/tb_opb_register_ppc2simulink.sv - self-checking bench for opb_register_ppc2simulink
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01080200;
  localparam logic [31:0] HIGH = 32'h010802FF;
  localparam logic [31:0] INIT = 32'h5A5AC3C3;

  logic        clk;
  logic        rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel;
  logic        seq_addr;
  logic [0:31] sl_dbus;
  logic        sl_xfer_ack;
  logic        sl_err_ack;
  logic        sl_retry;
  logic        sl_tout_sup;
  logic [31:0] user_data_out;
  logic        user_data_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] data;
    logic        exp_ack;
    logic [31:0] exp_rdata;
    logic        exp_valid;
    logic [31:0] exp_reg;
  } vec_t;

  exp_t ack_q[$];
  exp_t val_q[$];
  exp_t mon_e;
  vec_t vecs[16];

  opb_register_ppc2simulink #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH),
    .C_INIT     (INIT)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .OPB_ABus        (abus),
    .OPB_BE          (be),
    .OPB_DBus        (dbus),
    .OPB_RNW         (rnw),
    .OPB_select      (sel),
    .OPB_seqAddr     (seq_addr),
    .Sl_DBus         (sl_dbus),
    .Sl_xferAck      (sl_xfer_ack),
    .Sl_errAck       (sl_err_ack),
    .Sl_retry        (sl_retry),
    .Sl_toutSup      (sl_tout_sup),
    .user_data_out   (user_data_out),
    .user_data_valid (user_data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Scoreboard: every ack and valid pulse must match the next queued expectation, on its cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sl_xfer_ack) begin
        if (ack_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc_n);
        end else begin
          mon_e = ack_q.pop_front();
          check("ack_cycle", cyc_n, mon_e.cyc);
          check("ack_rdata", sl_dbus, mon_e.data);
        end
      end else begin
        check("dbus_idle", sl_dbus, 32'h0);
      end
      if (user_data_valid) begin
        if (val_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid expected none (cycle %0d)", cyc_n);
        end else begin
          mon_e = val_q.pop_front();
          check("valid_cycle", cyc_n, mon_e.cyc);
          check("valid_data", user_data_out, mon_e.data);
        end
      end
    end
  end

  task automatic idle_bus();
    sel  = 1'b0;
    rnw  = 1'b0;
    abus = 32'h0;
    be   = 4'h0;
    dbus = 32'h0;
  endtask

  task automatic check_drained(input string name);
    check({name, "_ack_pending"}, ack_q.size(), 0);
    check({name, "_valid_pending"}, val_q.size(), 0);
    ack_q.delete();
    val_q.delete();
  endtask

  task automatic drive(input logic [31:0] a, input logic r, input logic [3:0] b, input logic [31:0] d);
    abus = a;
    rnw  = r;
    be   = b;
    dbus = d;
    sel  = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    @(posedge clk); #1;
    k = cyc_n;
    drive(v.addr, v.rnw, v.be, v.data);
    if (v.exp_ack)   ack_q.push_back('{k + 1, v.exp_rdata});
    if (v.exp_valid) val_q.push_back('{k + 2, v.exp_reg});
    repeat (2) @(posedge clk);
    #1 idle_bus();
    repeat (2) @(posedge clk);
    #1;
    check_drained(v.name);
    check({v.name, "_reg"}, user_data_out, v.exp_reg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0]  = '{"wr_full",      BASE,         1'b0, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[1]  = '{"rd_base",      BASE,         1'b1, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{"wr_partial",   BASE,         1'b0, 4'b0101, 32'h11223344, 1'b1, 32'h0,        1'b1, 32'hDE22BE44};
    vecs[3]  = '{"wr_be0",       BASE + 1,     1'b0, 4'b0000, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 32'hDE22BE44};
    vecs[4]  = '{"rd_off4",      BASE + 4,     1'b1, 4'b1111, 32'h0,        1'b1, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[5]  = '{"wr_off4",      BASE + 4,     1'b0, 4'b1111, 32'h12345678, 1'b1, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[6]  = '{"wr_high",      HIGH,         1'b0, 4'b1111, 32'hAAAAAAAA, 1'b1, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[7]  = '{"wr_below",     BASE - 4,     1'b0, 4'b1111, 32'h55555555, 1'b0, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[8]  = '{"wr_above",     HIGH + 1,     1'b0, 4'b1111, 32'h55555555, 1'b0, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[9]  = '{"rd_below",     BASE - 4,     1'b1, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[10] = '{"wr_lane0",     BASE,         1'b0, 4'b1000, 32'hAB000000, 1'b1, 32'h0,        1'b1, 32'hAB22BE44};
    vecs[11] = '{"wr_low_half",  BASE,         1'b0, 4'b0011, 32'h0000CAFE, 1'b1, 32'h0,        1'b1, 32'hAB22CAFE};
    vecs[12] = '{"rd_merged",    BASE,         1'b1, 4'b0000, 32'h0,        1'b1, 32'hAB22CAFE, 1'b0, 32'hAB22CAFE};
    vecs[13] = '{"wr_byte_addr", BASE + 3,     1'b0, 4'b1111, 32'h600DF00D, 1'b1, 32'h0,        1'b1, 32'h600DF00D};
    vecs[14] = '{"rd_byte_addr", BASE + 2,     1'b1, 4'b1111, 32'h0,        1'b1, 32'h600DF00D, 1'b0, 32'h600DF00D};
    vecs[15] = '{"rd_top_word",  32'h010802FC, 1'b1, 4'b1111, 32'h0,        1'b1, 32'h0,        1'b0, 32'h600DF00D};

    seq_addr = 1'b0;
    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Reset state held steady for ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_reg", user_data_out, INIT);
      check("reset_ack", sl_xfer_ack, 1'b0);
      check("reset_valid", user_data_valid, 1'b0);
      check("reset_consts", {sl_err_ack, sl_retry, sl_tout_sup}, 3'b000);
    end

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Master drops select in the ACK cycle: no ack, no write.
    @(posedge clk); #1;
    drive(BASE, 1'b0, 4'b1111, 32'h0BADF00D);
    @(posedge clk); #1;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check_drained("abort");
    check("abort_reg", user_data_out, 32'h600DF00D);

    // Select held for nine cycles: three acks three cycles apart, a valid after each.
    @(posedge clk); #1;
    k = cyc_n;
    drive(BASE, 1'b0, 4'b1111, 32'h13579BDF);
    for (int j = 0; j < 3; j++) begin
      ack_q.push_back('{k + 1 + 3 * j, 32'h0});
      val_q.push_back('{k + 2 + 3 * j, 32'h13579BDF});
    end
    repeat (9) @(posedge clk);
    #1 idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check_drained("burst");
    check("burst_reg", user_data_out, 32'h13579BDF);

    // Reset arriving with a request: the request is dropped and the register reinitialised.
    @(posedge clk); #1;
    rst = 1'b1;
    drive(BASE, 1'b0, 4'b1111, 32'hFFFFFFFF);
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_drained("reset_mid");
    check("reset_mid_reg", user_data_out, INIT);

    // The register still works after that reset.
    run_vec('{"wr_after_rst", BASE, 1'b0, 4'b1111, 32'h0F1E2D3C, 1'b1, 32'h0, 1'b1, 32'h0F1E2D3C});
    run_vec('{"rd_after_rst", BASE, 1'b1, 4'b1111, 32'h0,        1'b1, 32'h0F1E2D3C, 1'b0, 32'h0F1E2D3C});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
